// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: HTRANS encoding and the address-phase register bundle.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    // Widest word index any 32-bit byte address can carry
    localparam int unsigned AHB_IDX_W = 30;

    typedef struct packed {
        logic                 write;
        logic [AHB_IDX_W-1:0] index;
        logic                 valid;
    } aphase_t;

endpackage

// File: rtl/ram_array.sv
// Word-wide register storage: async clear, one synchronous write port, one combinational read port.
module ram_array #(
    parameter int IDX_W      = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ram.sv
// Zero-wait-state AHB-Lite slave around a register-based word RAM.
module ram
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [1:0]            HTRANS,
    input  logic                  HSEL,
    input  logic                  HREADY,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT
);

    localparam int IDX_W = ADDR_WIDTH - 2;

    aphase_t               aphase_q;
    logic                  xfer_valid;
    logic [DATA_WIDTH-1:0] rd_word;

    assign xfer_valid = HSEL && HREADY &&
                        (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            aphase_q <= '0;
        end else if (xfer_valid) begin
            aphase_q.write <= HWRITE;
            aphase_q.index <= AHB_IDX_W'(HADDR[ADDR_WIDTH-1:2]);
            aphase_q.valid <= 1'b1;
        end else begin
            aphase_q.valid <= 1'b0;
        end
    end

    // Write commits on the edge that ends its data phase, so a following read sees it
    ram_array #(
        .IDX_W      (IDX_W),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .we    (aphase_q.valid && aphase_q.write),
        .waddr (aphase_q.index[IDX_W-1:0]),
        .wdata (HWDATA),
        .raddr (aphase_q.index[IDX_W-1:0]),
        .rdata (rd_word)
    );

    assign HRDATA    = (aphase_q.valid && !aphase_q.write) ? rd_word : '0;
    assign HREADYOUT = 1'b1;

    logic unused_ok;
    assign unused_ok = ^{HADDR[1:0], aphase_q.index[AHB_IDX_W-1:IDX_W]};

endmodule

// File: tb/tb_ram.sv
// Bench for ram: directed and random AHB traffic against an array-based reference model.
module tb_ram;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic [AW-1:0] HADDR;
    logic          HWRITE;
    logic [1:0]    HTRANS;
    logic          HSEL;
    logic          HREADY;
    logic [DW-1:0] HWDATA;
    logic [DW-1:0] HRDATA;
    logic          HREADYOUT;

    int errors = 0;
    int checks = 0;

    ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HADDR     (HADDR),
        .HWRITE    (HWRITE),
        .HTRANS    (HTRANS),
        .HSEL      (HSEL),
        .HREADY    (HREADY),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT)
    );

    always #5 HCLK = ~HCLK;

    // Reference model: a word array plus the transfer accepted last cycle
    logic [DW-1:0] mmem [256];
    bit            m_pend = 1'b0;
    bit            m_wr   = 1'b0;
    int            m_idx  = 0;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < 256; i++) mmem[i] <= '0;
            m_pend <= 1'b0;
        end else begin
            if (m_pend && m_wr) mmem[m_idx] <= HWDATA;
            m_pend <= HSEL && HREADY && HTRANS[1];
            m_wr   <= HWRITE;
            m_idx  <= int'(HADDR) / 4;
        end
    end

    function automatic logic [DW-1:0] model_rdata();
        return (m_pend && !m_wr) ? mmem[m_idx] : '0;
    endfunction

    // Continuous comparison every cycle, away from the active edge
    always @(negedge HCLK) begin
        checks++;
        if (HRDATA !== model_rdata()) begin
            errors++;
            $display("FAIL hrdata_model t=%0t got=%h want=%h", $time, HRDATA, model_rdata());
        end
        checks++;
        if (HREADYOUT !== 1'b1) begin
            errors++;
            $display("FAIL hreadyout t=%0t got=%b want=1", $time, HREADYOUT);
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // One address phase; write data is driven during the following cycle
    task automatic step(input bit sel, input bit rdy, input logic [1:0] tr, input bit wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd);
        HSEL   = sel;
        HREADY = rdy;
        HTRANS = tr;
        HWRITE = wr;
        HADDR  = a;
        @(posedge HCLK);
        #2;
        HWDATA = wd;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        step(1'b1, 1'b1, 2'b10, 1'b1, a, d);
    endtask

    task automatic rd_chk(input string name, input logic [AW-1:0] a, input logic [DW-1:0] want);
        step(1'b1, 1'b1, 2'b10, 1'b0, a, 32'hCAFE_F00D);
        @(negedge HCLK);
        chk(name, HRDATA, want);
    endtask

    task automatic idle();
        step(1'b1, 1'b1, 2'b00, 1'b0, '0, '0);
    endtask

    initial begin
        HRESETn = 1'b0;
        HADDR = '0; HWRITE = 1'b0; HTRANS = 2'b00; HSEL = 1'b0; HREADY = 1'b1; HWDATA = '0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("reset_hrdata", HRDATA, 32'h0);
        HRESETn = 1'b1;

        rd_chk("rd_02f_after_reset", 10'h02F, 32'h0);
        rd_chk("rd_000_after_reset", 10'h000, 32'h0);

        wr(10'h000, 32'hA5A5A5A5);
        wr(10'h008, 32'h12345678);
        wr(10'h00C, 32'h87654321);
        rd_chk("rd_000", 10'h000, 32'hA5A5A5A5);
        rd_chk("rd_008", 10'h008, 32'h12345678);
        rd_chk("rd_00c", 10'h00C, 32'h87654321);

        wr(10'h01F, 32'h88888888);
        rd_chk("rd_01c_unaligned", 10'h01C, 32'h88888888);
        rd_chk("rd_01f_unaligned", 10'h01F, 32'h88888888);
        rd_chk("rd_004_no_alias", 10'h004, 32'h0);

        wr(10'h010, 32'hDEADBEEF);
        rd_chk("raw_010", 10'h010, 32'hDEADBEEF);

        step(1'b1, 1'b1, 2'b00, 1'b1, 10'h010, 32'h11111111);
        step(1'b0, 1'b1, 2'b10, 1'b1, 10'h010, 32'h11111111);
        step(1'b1, 1'b0, 2'b10, 1'b1, 10'h010, 32'h11111111);
        step(1'b1, 1'b1, 2'b01, 1'b1, 10'h010, 32'h11111111);
        rd_chk("unqualified_no_write", 10'h010, 32'hDEADBEEF);

        // Read followed by write to the same word returns the old data
        step(1'b1, 1'b1, 2'b10, 1'b0, 10'h008, '0);
        HSEL = 1'b1; HREADY = 1'b1; HTRANS = 2'b11; HWRITE = 1'b1; HADDR = 10'h008;
        @(negedge HCLK);
        chk("war_old_data", HRDATA, 32'h12345678);
        @(posedge HCLK); #2; HWDATA = 32'h0BADF00D;
        rd_chk("war_new_data", 10'h008, 32'h0BADF00D);

        // Reset during a write data phase
        wr(10'h014, 32'h55555555);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
        #1 HRESETn = 1'b0;
        @(negedge HCLK);
        chk("hrdata_in_reset", HRDATA, 32'h0);
        @(posedge HCLK); #2;
        HRESETn = 1'b1;
        rd_chk("post_reset_014", 10'h014, 32'h0);
        rd_chk("post_reset_010", 10'h010, 32'h0);
        rd_chk("post_reset_000", 10'h000, 32'h0);
        rd_chk("post_reset_01c", 10'h01C, 32'h0);

        // Random traffic over a small window so addresses collide often
        for (int n = 0; n < 3000; n++) begin
            step(($urandom % 4) != 0, ($urandom % 4) != 0, 2'($urandom), 1'($urandom),
                 AW'($urandom % 64), $urandom);
        end
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout t=%0t", $time);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
